// File: rtl/pl_stage_reg.sv
// Pipeline stage register: control + data through a valid/ready handshake,
// optional two-entry skid buffer, flush that squashes control only, squash counter.
module pl_stage_reg #(
    parameter int                CTRL_W   = 16,
    parameter int                DATA_W   = 128,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0,
    parameter bit                SKID     = 1'b1,
    parameter int                CNT_W    = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  squash_cnt
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t            st, nxt;
    logic [CTRL_W-1:0] h_ctrl, s_ctrl;
    logic [DATA_W-1:0] h_data, s_data;
    logic [CNT_W-1:0]  cnt;
    logic              h_vld, s_vld, accept, release_h;
    logic              ld_h_in, ld_h_s, ld_s;
    logic [1:0]        killed;
    logic [CNT_W:0]    cnt_sum;

    assign h_vld = (st != EMPTY);
    assign s_vld = (st == TWO);

    // SKID=1 keeps out_ready off the in_ready path; SKID=0 lets a stalled-free
    // consumer pull a new entry into H in the same cycle it drains the old one.
    generate
        if (SKID) begin : g_skid
            assign in_ready = !s_vld && !flush && !RST;
        end else begin : g_noskid
            assign in_ready = (!h_vld || out_ready) && !flush && !RST;
        end
    endgenerate

    assign out_valid  = h_vld && !flush;
    assign out_ctrl   = h_ctrl;
    assign out_data   = h_data;
    assign occupancy  = st;
    assign squash_cnt = cnt;

    assign accept    = in_valid && in_ready;
    assign release_h = out_valid && out_ready;

    always_comb begin
        nxt     = st;
        ld_h_in = 1'b0;
        ld_h_s  = 1'b0;
        ld_s    = 1'b0;
        if (flush) begin
            nxt = EMPTY;
        end else begin
            case (st)
                EMPTY: if (accept) begin
                    nxt     = ONE;
                    ld_h_in = 1'b1;
                end
                ONE: begin
                    if (accept && release_h) begin
                        ld_h_in = 1'b1;
                    end else if (accept && SKID) begin
                        nxt  = TWO;
                        ld_s = 1'b1;
                    end else if (release_h) begin
                        nxt = EMPTY;
                    end
                end
                TWO: if (release_h) begin
                    nxt    = ONE;
                    ld_h_s = 1'b1;
                end
                default: nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) st <= EMPTY;
        else     st <= nxt;
    end

    // Saturating add; CNT_W+1 bits always hold max + 2 without wrapping.
    assign killed  = {1'b0, h_vld} + {1'b0, s_vld};
    assign cnt_sum = {1'b0, cnt} + (CNT_W+1)'(killed);

    always_ff @(posedge CLK) begin
        if (RST) begin
            h_ctrl <= CTRL_RST;
            s_ctrl <= CTRL_RST;
            h_data <= '0;
            s_data <= '0;
            cnt    <= '0;
        end else if (flush) begin
            h_ctrl <= CTRL_RST;
            s_ctrl <= CTRL_RST;
            if (cnt_sum > {1'b0, {CNT_W{1'b1}}}) cnt <= {CNT_W{1'b1}};
            else                                 cnt <= cnt_sum[CNT_W-1:0];
        end else begin
            if (ld_h_in) begin
                h_ctrl <= in_ctrl;
                h_data <= in_data;
            end else if (ld_h_s) begin
                h_ctrl <= s_ctrl;
                h_data <= s_data;
            end
            if (ld_s) begin
                s_ctrl <= in_ctrl;
                s_data <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_pl_stage_reg.sv
// Directed bench for pl_stage_reg: one SKID=1 instance (CNT_W=2) and one SKID=0 instance.
module tb_pl_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    int          total = 0;
    int          bad   = 0;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [15:0] a_in_ctrl, a_out_ctrl;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ, a_sq;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [15:0] b_in_ctrl, b_out_ctrl;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;
    logic [7:0]  b_sq;

    always #5 clk = ~clk;

    pl_stage_reg #(.CTRL_W(16), .DATA_W(32), .CTRL_RST(16'h00A5), .SKID(1'b1), .CNT_W(2)) u_a (
        .CLK(clk), .RST(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .flush(a_flush), .occupancy(a_occ), .squash_cnt(a_sq)
    );

    pl_stage_reg #(.CTRL_W(16), .DATA_W(32), .CTRL_RST(16'h0000), .SKID(1'b0), .CNT_W(8)) u_b (
        .CLK(clk), .RST(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .flush(b_flush), .occupancy(b_occ), .squash_cnt(b_sq)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_push(input logic [15:0] c, input logic [31:0] d);
        a_in_valid = 1'b1;
        a_in_ctrl  = c;
        a_in_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 0; a_in_ctrl = '0; a_in_data = '0; a_out_ready = 0; a_flush = 0;
        b_in_valid = 0; b_in_ctrl = '0; b_in_data = '0; b_out_ready = 0; b_flush = 0;
        #1;
        chk("in_ready_during_rst", a_in_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", a_out_valid, 1'b0);
        chk("rst_out_ctrl", a_out_ctrl, 16'h00A5);
        chk("rst_out_data", a_out_data, 32'h0);
        chk("rst_occ", a_occ, 2'd0);
        chk("rst_squash", a_sq, 2'd0);
        chk("rst_in_ready", a_in_ready, 1'b1);
        chk("rst_b_in_ready", b_in_ready, 1'b1);
        chk("rst_b_out_ctrl", b_out_ctrl, 16'h0000);

        // Stream at full rate
        a_out_ready = 1'b1;
        a_push(16'h0011, 32'h1);
        tick();
        a_push(16'h0022, 32'h2); #1;
        chk("stream_ctrl0", a_out_ctrl, 16'h0011);
        chk("stream_vld0", a_out_valid, 1'b1);
        chk("stream_occ0", a_occ, 2'd1);
        tick();
        a_push(16'h0033, 32'h3); #1;
        chk("stream_ctrl1", a_out_ctrl, 16'h0022);
        chk("stream_vld1", a_out_valid, 1'b1);
        chk("stream_occ1", a_occ, 2'd1);
        tick();
        a_in_valid = 1'b0; #1;
        chk("stream_ctrl2", a_out_ctrl, 16'h0033);
        chk("stream_data2", a_out_data, 32'h3);
        chk("stream_vld2", a_out_valid, 1'b1);
        tick();
        chk("stream_drain_occ", a_occ, 2'd0);
        chk("stream_drain_vld", a_out_valid, 1'b0);

        // Stall fills the skid buffer, then drain in order
        a_out_ready = 1'b0;
        a_push(16'h000A, 32'hAAAA0001);
        tick();
        a_push(16'h000B, 32'hBBBB0002);
        tick();
        a_in_valid = 1'b0; #1;
        chk("stall_occ", a_occ, 2'd2);
        chk("stall_in_ready", a_in_ready, 1'b0);
        chk("stall_ctrl", a_out_ctrl, 16'h000A);
        chk("stall_data", a_out_data, 32'hAAAA0001);
        a_push(16'h000C, 32'hCCCC0003);
        tick();
        a_in_valid = 1'b0; #1;
        chk("stall_hold_ctrl", a_out_ctrl, 16'h000A);
        chk("stall_hold_occ", a_occ, 2'd2);
        a_out_ready = 1'b1; #1;
        chk("drain_a_vld", a_out_valid, 1'b1);
        tick();
        chk("drain_b_ctrl", a_out_ctrl, 16'h000B);
        chk("drain_b_data", a_out_data, 32'hBBBB0002);
        chk("drain_b_occ", a_occ, 2'd1);
        tick();
        chk("drain_done_occ", a_occ, 2'd0);

        // Flush in TWO (out_ready high too: flush must win)
        a_out_ready = 1'b0;
        a_push(16'h0001, 32'hDEADBEEF);
        tick();
        a_push(16'h0002, 32'hDEAD0002);
        tick();
        a_in_valid = 1'b0;
        a_flush = 1'b1; a_out_ready = 1'b1; #1;
        chk("flush_out_valid", a_out_valid, 1'b0);
        chk("flush_in_ready", a_in_ready, 1'b0);
        tick();
        a_flush = 1'b0; #1;
        chk("flush_occ", a_occ, 2'd0);
        chk("flush_ctrl", a_out_ctrl, 16'h00A5);
        chk("flush_data", a_out_data, 32'hDEADBEEF);
        chk("flush_squash", a_sq, 2'd2);

        // Saturation: 2 -> 3 -> 3
        for (int r = 0; r < 2; r++) begin
            a_out_ready = 1'b0;
            a_push(16'h0040, 32'h40);
            tick();
            a_push(16'h0041, 32'h41);
            tick();
            a_in_valid = 1'b0;
            a_flush = 1'b1;
            tick();
            a_flush = 1'b0; #1;
            chk("sat_squash", a_sq, 2'd3);
        end

        // Reset mid-stall in TWO
        a_push(16'h0050, 32'h5050);
        tick();
        a_push(16'h0051, 32'h5151);
        tick();
        a_in_valid = 1'b0; #1;
        chk("pre_rst_occ", a_occ, 2'd2);
        rst = 1'b1; #1;
        chk("rst_mid_in_ready", a_in_ready, 1'b0);
        tick();
        rst = 1'b0; #1;
        chk("rst_mid_vld", a_out_valid, 1'b0);
        chk("rst_mid_occ", a_occ, 2'd0);
        chk("rst_mid_data", a_out_data, 32'h0);
        chk("rst_mid_squash", a_sq, 2'd0);
        chk("rst_mid_in_ready_after", a_in_ready, 1'b1);

        // SKID=0 instance
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_ctrl = 16'h0051; b_in_data = 32'h5151;
        tick();
        b_in_ctrl = 16'h0052; b_in_data = 32'h5252; #1;
        chk("b_stall_in_ready", b_in_ready, 1'b0);
        chk("b_stall_occ", b_occ, 2'd1);
        chk("b_stall_ctrl", b_out_ctrl, 16'h0051);
        tick();
        chk("b_hold_ctrl", b_out_ctrl, 16'h0051);
        chk("b_hold_occ", b_occ, 2'd1);
        b_out_ready = 1'b1; #1;
        chk("b_comb_in_ready", b_in_ready, 1'b1);
        tick();
        chk("b_replace_ctrl", b_out_ctrl, 16'h0052);
        chk("b_replace_data", b_out_data, 32'h5252);
        chk("b_replace_occ", b_occ, 2'd1);
        chk("b_replace_vld", b_out_valid, 1'b1);
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b1;
        tick();
        b_flush = 1'b0; #1;
        chk("b_flush_occ", b_occ, 2'd0);
        chk("b_flush_squash", b_sq, 8'd1);
        chk("b_flush_data", b_out_data, 32'h5252);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pl_stage_reg.md
# pl_stage_reg

Parametrised pipeline stage register for the A0 pipeline, the generalised replacement for the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). Each instance carries a control field and a data field through a valid/ready handshake with an optional two-entry skid buffer. It supports flush, which squashes control but keeps data, and it counts squashed instructions. A stage instantiates it once with its packed control and data vectors.

## Interface
Parameters:
- CTRL_W, 16: width of control field (WB/MEM/EX control bits); this field is squashed on flush.
- DATA_W, 128: width of data field (rdat, immediates, register indices, pcn); never squashed.
- CTRL_RST, '0: value loaded into control fields on reset and flush.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 8: width of the squash counter.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  reset; one clock; reset is synchronous and active-high.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  block accepts entry this cycle.
- in_ctrl  in  CTRL_W  upstream control.
- in_data  in  DATA_W  upstream data.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts (0 = stall).
- out_ctrl  out  CTRL_W  control of head entry.
- out_data  out  DATA_W  data of head entry.
- flush  in  1  squash all held entries.
- occupancy  out  2  number of valid entries (0..2; 0..1 when SKID=0).
- squash_cnt  out  CNT_W  saturating count of valid entries killed by flush.

## Operation
- Storage: head entry (H) drives out_*. Skid entry (S) exists only when SKID=1. Each entry has a valid bit, a control field and a data field.
- Accept = in_valid & in_ready. Release = out_valid & out_ready.
- out_valid = H.valid & !flush. out_ctrl/out_data = H fields, unmasked.
- SKID=1: in_ready = !S.valid & !flush & !RST.
- SKID=0: in_ready = (!H.valid | out_ready) & !flush & !RST.
- States, equal to occupancy:
  - EMPTY: Accept -> ONE, H loaded.
  - ONE: Accept & !Release -> TWO, S loaded. Release & !Accept -> EMPTY. Accept & Release -> ONE, H replaced by input.
  - TWO: in_ready=0. Release -> ONE, H <= S. Otherwise hold.
  - SKID=0: TWO is unreachable. ONE with Accept & Release reloads H.
- Stall: out_ready=0 holds all fields bit-stable. Data is never overwritten while valid.
- Flush has priority over everything except RST:
  - All valid bits clear and both control fields load CTRL_RST.
  - Data fields hold their value.
  - No Accept and no Release occur in the flush cycle.
  - Next state is EMPTY.
- squash_cnt adds (H.valid + S.valid) on each flush and saturates at 2^CNT_W-1 with no wrap. When at max-1 with 2 valid entries killed, it goes to max.
- Reset (RST=1 at edge): valid bits 0, control fields = CTRL_RST, data fields = 0, squash_cnt = 0.
  - Outputs after reset: out_valid 0, out_ctrl CTRL_RST, out_data 0, occupancy 0, squash_cnt 0, in_ready 1.
  - While RST is high, in_ready = 0.
  - Reset in the middle of a stall or in TWO discards everything and does not count toward squash_cnt.

## Timing
- Latency: an entry accepted at edge N is on out_* with out_valid=1 after edge N, so it is visible in cycle N+1.
- Throughput: 1 entry/cycle sustained while out_ready=1. No bubble is inserted in either SKID mode.
- SKID=1: in_ready depends only on registers plus flush/RST. There is no out_ready -> in_ready combinational path.
- SKID=0: out_ready -> in_ready is a combinational path.
- Ordering is FIFO. S is never presented before H.
- flush and out_ready in the same cycle: flush wins and nothing is released.

## Test plan
- Stream: SKID=1, out_ready=1, present ctrl=0x0011, 0x0022, 0x0033 on consecutive cycles -> same values appear on out_ctrl one cycle later each, out_valid continuous, occupancy stays 1.
- Stall/skid: out_ready=0, push A then B -> after 2 edges occupancy=2, in_ready=0, out shows A. Raise out_ready -> A then B in order, then occupancy=0.
- Flush in TWO: hold A,B with data=0xDEAD..., assert flush one cycle -> out_valid=0 in that cycle, then occupancy=0, out_ctrl=CTRL_RST, out_data unchanged, squash_cnt +2.
- Saturation: CNT_W=2, repeatedly flush with 2 entries -> squash_cnt 0,2,3,3.
- Reset mid-stall: occupancy=2, RST=1 one edge -> out_valid=0, occupancy=0, out_data=0, squash_cnt=0, in_ready=0 during RST and 1 after.
- SKID=0 instance: out_ready=0 with H valid -> in_ready=0. out_ready=1 with in_valid -> in_ready=1 same cycle and H replaced at the edge, occupancy stays 1.
